// File: rtl/game_pkg.sv
// Shared types and constants for the script sequencer and the Game it drives.
package game_pkg;

  localparam int DEPTH          = 32;
  localparam int AW             = 5;
  localparam int STATE_W        = 5;
  localparam int ST_WIN         = 9;
  localparam int ST_LOSE_MOT    = 10;
  localparam int ST_LOSE_SCROLL = 13;

  typedef enum logic [1:0] {
    DEC_A = 2'b00,
    DEC_B = 2'b01,
    DEC_C = 2'b10,
    DEC_D = 2'b11
  } decision_t;

  typedef enum logic [1:0] {
    RES_NONE      = 2'b00,
    RES_WIN       = 2'b01,
    RES_LOSE      = 2'b10,
    RES_EXHAUSTED = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRST  = 3'd1,
    S_PLAY  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/game_script_sequencer_script_mem.sv
// Script storage: DEPTH x 2-bit register array, synchronous write, asynchronous read.
module script_mem #(
  parameter int DEPTH = game_pkg::DEPTH,
  parameter int AW    = game_pkg::AW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data
);

  logic [1:0] mem_q [DEPTH];

  // One register per entry; an address with no matching entry writes nothing.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the decision when this entry is addressed by an enabled write.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          mem_q[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/game_script_sequencer.sv
// Plays a stored decision script into the Game FSM and reports how the run ended.
module game_script_sequencer #(
  parameter int DEPTH        = game_pkg::DEPTH,
  parameter int AW           = game_pkg::AW,
  parameter int STATE_W      = game_pkg::STATE_W,
  parameter int WIN_STATE    = game_pkg::ST_WIN,
  parameter int LOSE_STATE_A = game_pkg::ST_LOSE_MOT,
  parameter int LOSE_STATE_B = game_pkg::ST_LOSE_SCROLL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [1:0]         wr_data,
  input  logic [AW:0]        script_len,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic [AW:0]        step_count,
  output logic               game_reset,
  output logic [1:0]         Decision,
  input  logic [STATE_W-1:0] game_state
);

  import game_pkg::*;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  seq_state_t  state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] step_q, step_d;
  result_t     result_q, result_d;

  logic        busy_c, done_c, grst_c;
  decision_t   dec_c;
  logic        mem_we;
  logic [1:0]  mem_rd;
  logic        term_win, term_lose;

  // Script is frozen for the whole run: writes land only while idle.
  assign mem_we = wr_en && (state_q == S_IDLE);

  script_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ptr_q),
    .rd_data (mem_rd)
  );

  assign term_win  = (game_state == STATE_W'(WIN_STATE));
  assign term_lose = (game_state == STATE_W'(LOSE_STATE_A)) ||
                     (game_state == STATE_W'(LOSE_STATE_B));

  // State and run bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      step_q   <= '0;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

  // Next-state and Moore-style outputs; the terminal check pre-empts issuing.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    step_d   = step_q;
    result_d = result_q;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    grst_c   = 1'b0;
    dec_c    = DEC_A;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (script_len == '0) begin
            // Empty script: report exhausted without touching Game.
            result_d = RES_EXHAUSTED;
            step_d   = '0;
            state_d  = S_FIN;
          end else begin
            len_d    = (script_len > DEPTH_L) ? DEPTH_L : script_len;
            ptr_d    = '0;
            step_d   = '0;
            result_d = RES_NONE;
            state_d  = S_GRST;
          end
        end
      end
      S_GRST: begin
        busy_c  = 1'b1;
        grst_c  = 1'b1;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        busy_c = 1'b1;
        if (term_win) begin
          result_d = RES_WIN;
          state_d  = S_FIN;
        end else if (term_lose) begin
          result_d = RES_LOSE;
          state_d  = S_FIN;
        end else begin
          dec_c = decision_t'(mem_rd);
          ptr_d = ptr_q + AW'(1);
          if (step_q != DEPTH_L) begin
            step_d = step_q + (AW+1)'(1);
          end
          if ({1'b0, ptr_q} == (len_q - (AW+1)'(1))) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // One idle cycle so Game's response to the last decision is seen.
        busy_c = 1'b1;
        if (term_win) begin
          result_d = RES_WIN;
        end else if (term_lose) begin
          result_d = RES_LOSE;
        end else begin
          result_d = RES_EXHAUSTED;
        end
        state_d = S_FIN;
      end
      S_FIN: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = busy_c;
  assign done       = done_c;
  assign game_reset = reset | grst_c;
  assign Decision   = dec_c;
  assign result     = result_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_game_script_sequencer.sv
// Directed bench: game_state is driven directly, expectations are hand-computed.
module tb_game_script_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [1:0] wr_data;
  logic [5:0] script_len;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] result;
  logic [5:0] step_count;
  logic       game_reset;
  logic [1:0] Decision;
  logic [4:0] game_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  game_script_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .script_len (script_len),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .step_count (step_count),
    .game_reset (game_reset),
    .Decision   (Decision),
    .game_state (game_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    script_len = '0; start = 1'b0; game_state = 5'd1;
    tick(); tick();
    chk("rst_game_reset", game_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_step", step_count, 0);
    chk("rst_decision", Decision, 0);
    reset = 1'b0;
    #1 chk("rel_game_reset", game_reset, 0);

    wr(5'd0, 2'b01); wr(5'd1, 2'b10); wr(5'd2, 2'b10); wr(5'd3, 2'b00);

    // Run 1: full script, Game never terminates.
    script_len = 6'd4; start = 1'b1;
    tick(); start = 1'b0;
    chk("r1_grst", game_reset, 1);
    chk("r1_grst_busy", busy, 1);
    chk("r1_grst_dec", Decision, 0);
    tick(); chk("r1_dec0", Decision, 2'b01);
    chk("r1_play_grst", game_reset, 0);
    tick(); chk("r1_dec1", Decision, 2'b10);
    tick(); chk("r1_dec2", Decision, 2'b10);
    tick(); chk("r1_dec3", Decision, 2'b00);
    chk("r1_dec3_busy", busy, 1);
    tick(); chk("r1_drain_busy", busy, 1);
    chk("r1_drain_done", done, 0);
    tick(); chk("r1_done", done, 1);
    chk("r1_fin_busy", busy, 0);
    chk("r1_result", result, 2'b11);
    chk("r1_step", step_count, 4);
    tick(); chk("r1_done_off", done, 0);
    chk("r1_result_held", result, 2'b11);

    // Run 2: win after the second decision.
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk("r2_dec0", Decision, 2'b01);
    tick(); chk("r2_dec1", Decision, 2'b10);
    tick(); game_state = 5'd9;
    #1 chk("r2_no_dec2", Decision, 2'b00);
    tick(); game_state = 5'd1;
    chk("r2_done", done, 1);
    chk("r2_result", result, 2'b01);
    chk("r2_step", step_count, 2);
    tick();

    // Run 3: lost to scrolling on the first PLAY cycle.
    start = 1'b1;
    tick(); start = 1'b0; game_state = 5'd13;
    tick(); chk("r3_dec", Decision, 2'b00);
    chk("r3_busy", busy, 1);
    tick(); game_state = 5'd1;
    chk("r3_done", done, 1);
    chk("r3_result", result, 2'b10);
    chk("r3_step", step_count, 0);
    tick();

    // Run 4: empty script.
    script_len = 6'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("r4_done", done, 1);
    chk("r4_busy", busy, 0);
    chk("r4_game_reset", game_reset, 0);
    chk("r4_result", result, 2'b11);
    chk("r4_step", step_count, 0);
    tick(); chk("r4_done_off", done, 0);

    // Run 5: write and start while busy are both ignored.
    script_len = 6'd4; start = 1'b1;
    tick(); start = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 2'b11;
    tick(); wr_en = 1'b0;
    chk("r5_dec0", Decision, 2'b01);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("r5_dec1", Decision, 2'b10);
    tick(); tick(); tick();
    tick(); chk("r5_done", done, 1);
    chk("r5_result", result, 2'b11);
    tick(); chk("r5_idle_busy", busy, 0);

    // Run 6: original entry survives; reset lands mid-run.
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk("r6_dec0", Decision, 2'b01);
    tick(); tick();
    tick(); chk("r6_step_pre", step_count, 3);
    reset = 1'b1;
    #1 chk("r6_grst_during", game_reset, 1);
    tick();
    chk("r6_busy", busy, 0);
    chk("r6_result", result, 0);
    chk("r6_step", step_count, 0);
    chk("r6_dec", Decision, 0);
    chk("r6_grst_held", game_reset, 1);
    reset = 1'b0;
    #1 chk("r6_grst_rel", game_reset, 0);

    // Run 7: replay starts again from entry 0.
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk("r7_dec0", Decision, 2'b01);
    tick(); chk("r7_dec1", Decision, 2'b10);
    for (int c = 0; c < 20 && !done; c++) tick();
    chk("r7_done", done, 1);
    chk("r7_step", step_count, 4);
    tick();

    // Run 8: oversize length clamps to the full memory.
    for (int i = 0; i < 32; i++) wr(5'(i), 2'(i));
    script_len = 6'd40; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 60 && !done; c++) tick();
    chk("r8_done", done, 1);
    chk("r8_step", step_count, 32);
    chk("r8_result", result, 2'b11);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
